nibble_packer: RTL and testbench
================================

NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: nibbles per output word; legal range 2..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream nibble valid.
REQ-005 SHALL have port in_data  input  4  upstream nibble; this is the 4-bit output of the register-stage chain.
REQ-006 SHALL have port in_ready  output  1  nibble accepted when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port flush  input  1  single-cycle request to emit the partial word.
REQ-008 SHALL have port out_valid  output  1  output FIFO head valid.
REQ-009 SHALL have port out_data  output  4*NIBBLES  packed word at FIFO head.
REQ-010 SHALL have port out_last  output  1  head word was produced by a flush.
REQ-011 SHALL have port out_ready  input  1  word popped when out_valid && out_ready at a clk edge.

Function
REQ-012 SHALL pack little-endian: the first accepted nibble of a word goes to out_data[3:0], and nibble k goes to [4k+3:4k].
REQ-013 SHALL hold the assembly register, nibble counter nib_cnt (0..NIBBLES-1) and a 2-entry output FIFO (data plus last flag) with count 0..2.
REQ-014 SHALL push the completed word into the FIFO on the edge that accepts nibble NIBBLES-1, reset nib_cnt to 0, and assert out_valid on the following cycle (latency 1).
REQ-015 SHALL drive out_valid = (count != 0) and present the head entry on out_data/out_last; outputs SHALL be registered with no combinational path from in_* or flush.
REQ-016 SHALL drive in_ready = (state == FILL) && ((nib_cnt != NIBBLES-1) || (count < 2)), using registered count only; in_ready SHALL NOT depend on out_ready.
REQ-017 SHALL leave count unchanged when a push and a pop occur on the same edge, and SHALL leave the FIFO order unchanged.
REQ-018 SHALL implement the FSM with two states: FILL (normal operation) and FLUSH (a partial word is waiting for FIFO space).
REQ-019 In FILL, a flush with nib_cnt == 0 and no nibble accepted that cycle SHALL be a no-op.
REQ-020 In FILL, a flush otherwise SHALL include any nibble accepted that same cycle, zero the unfilled upper nibbles, and set the last flag to 1.
REQ-021 When count < 2, the flushed word SHALL be pushed on that same edge and nib_cnt SHALL go to 0.
REQ-022 When count == 2, the FSM SHALL go to FLUSH and keep the padded word.
REQ-023 If the accepted nibble completes a word on a flush cycle, that word SHALL be pushed with last = 1; this SHALL NOT cause an extra empty push.
REQ-024 In FLUSH, in_ready SHALL be 0 and flush SHALL be ignored.
REQ-025 The FSM SHALL leave FLUSH on the first edge where registered count < 2, pushing the pending word, clearing nib_cnt, and returning to FILL.
REQ-026 Non-flush words SHALL carry last = 0.
REQ-027 A pop SHALL remove exactly one entry; out_ready with out_valid = 0 SHALL have no effect.

Reset
REQ-028 With rst_n low at a clk edge, the block SHALL set state = FILL, nib_cnt = 0, count = 0, and the assembly register = 0.
REQ-029 With rst_n low at a clk edge, the block SHALL drive out_valid = 0, out_data = 0, out_last = 0, and in_ready = 1 on the next cycle.
REQ-030 Reset SHALL discard any partial word, pending flush, or stored FIFO entries, even in mid-operation; reset SHALL take priority over all other inputs.

Verification (NIBBLES = 4)
REQ-031 SHALL check a basic word: out_ready = 1, nibbles 1,2,3,4 on consecutive cycles -> out_data = 16'h4321, out_last = 0, out_valid high exactly one cycle after the 4th accept.
REQ-032 SHALL check backpressure: out_ready = 0, stream nibbles 0..F continuously -> in_ready drops when the 12th nibble is next to be accepted (nib_cnt = 3, count = 2); FIFO holds 16'h3210 then 16'h7654; raise out_ready -> both pop in order; the stream then resumes.
REQ-033 SHALL check a partial flush: nibbles A,B, then flush alone -> out_data = 16'h00BA, out_last = 1; a following word 1,2,3,4 carries out_last = 0.
REQ-034 SHALL check a flush with a concurrent nibble: nibbles 5,6, then nibble 7 with flush in the same cycle -> 16'h0765, last = 1; a flush with nib_cnt = 0 and no nibble produces no push.
REQ-035 SHALL check a flush while full: out_ready = 0, FIFO full, nibble 9, then flush -> FLUSH state and in_ready = 0; one out_ready pulse -> 16'h0009 with last = 1 is pushed on the next edge, the FSM returns to FILL, and in_ready = 1.
REQ-036 SHALL check reset mid-word: nibbles 1,2,3, then rst_n low for one edge, then nibbles 5,6,7,8 -> single output 16'h8765, with no trace of 1,2,3.

Source files
------------

// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles little-endian into NIBBLES-wide words and
// queues them in a 2-entry output FIFO; a flush emits a zero-padded partial word.
module nibble_packer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [3:0]           in_data,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [4*NIBBLES-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    typedef enum logic {FILL, FLUSH} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   nib_cnt_reg, nib_cnt_next;
    logic [W-1:0]    asm_reg, asm_next, asm_with;
    logic [W-1:0]    fifo_data_reg [2];
    logic            fifo_last_reg [2];
    logic            rd_ptr_reg, wr_ptr_reg;
    logic [1:0]      count_reg;

    logic            accept, pop, push, push_last;
    logic [W-1:0]    push_data;

    assign in_ready  = (state_reg == FILL) && ((nib_cnt_reg != LAST_NIB) || (count_reg < 2'd2));
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = fifo_data_reg[rd_ptr_reg];
    assign out_last  = fifo_last_reg[rd_ptr_reg];

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Assembly register with this cycle's accepted nibble dropped into its slot.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slot
            assign asm_with[4*gi +: 4] = (accept && (nib_cnt_reg == CW'(gi))) ? in_data
                                                                              : asm_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        push         = 1'b0;
        push_data    = asm_with;
        push_last    = 1'b0;
        state_next   = state_reg;
        nib_cnt_next = nib_cnt_reg;
        asm_next     = asm_reg;
        case (state_reg)
            FILL: begin
                if (accept && (nib_cnt_reg == LAST_NIB)) begin
                    // A completing nibble on a flush cycle marks this word last; no extra push.
                    push         = 1'b1;
                    push_last    = flush;
                    nib_cnt_next = '0;
                    asm_next     = '0;
                end else if (flush && (accept || (nib_cnt_reg != '0))) begin
                    if (count_reg < 2'd2) begin
                        push         = 1'b1;
                        push_last    = 1'b1;
                        nib_cnt_next = '0;
                        asm_next     = '0;
                    end else begin
                        state_next   = FLUSH;
                        asm_next     = asm_with;
                        nib_cnt_next = nib_cnt_reg + CW'(accept);
                    end
                end else if (accept) begin
                    asm_next     = asm_with;
                    nib_cnt_next = nib_cnt_reg + CW'(1);
                end
            end
            FLUSH: begin
                if (count_reg < 2'd2) begin
                    push         = 1'b1;
                    push_data    = asm_reg;
                    push_last    = 1'b1;
                    nib_cnt_next = '0;
                    asm_next     = '0;
                    state_next   = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= FILL;
            nib_cnt_reg <= '0;
            asm_reg     <= '0;
            rd_ptr_reg  <= 1'b0;
            wr_ptr_reg  <= 1'b0;
            count_reg   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_last_reg[i] <= 1'b0;
            end
        end else begin
            state_reg   <= state_next;
            nib_cnt_reg <= nib_cnt_next;
            asm_reg     <= asm_next;
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= push_data;
                fifo_last_reg[wr_ptr_reg] <= push_last;
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed scoreboard bench for nibble_packer (NIBBLES = 4): stimulus queues the
// expected words, an independent monitor compares every popped word.
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q [$];

    nibble_packer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Monitor: a pop happens on the next rising edge whenever valid && ready now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got data=%h last=%0b, required no output", out_data, out_last);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({out_data, out_last} !== e) begin
                    errors++;
                    $display("FAIL pop_word: got data=%h last=%0b, required data=%h last=%0b",
                             out_data, out_last, e[16:1], e[0]);
                end else begin
                    $display("pop data=%h last=%0b ok", out_data, out_last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic expect_word(input logic [15:0] d, input logic l);
        exp_q.push_back({d, l});
    endtask

    task automatic send(input logic [3:0] d, input logic fl);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 100 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        $display("sent nibble %h flush=%0b", d, fl);
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_out_valid", 16'(out_valid), 16'h0);
        chk("reset_out_data", out_data, 16'h0);
        chk("reset_out_last", 16'(out_last), 16'h0);
        chk("reset_in_ready", 16'(in_ready), 16'h1);

        // Basic word and one-cycle latency.
        expect_word(16'h4321, 1'b0);
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
        chk("basic_valid_before", 16'(out_valid), 16'h0);
        send(4'h4, 1'b0);
        chk("basic_valid_after", 16'(out_valid), 16'h1);
        chk("basic_data", out_data, 16'h4321);
        wait_drain();

        // Backpressure: two full words then stall with nib_cnt = 3.
        out_ready = 1'b0;
        expect_word(16'h3210, 1'b0); expect_word(16'h7654, 1'b0);
        expect_word(16'hBA98, 1'b0); expect_word(16'hFEDC, 1'b0);
        for (int i = 0; i < 11; i++) send(4'(i), 1'b0);
        chk("bp_in_ready_low", 16'(in_ready), 16'h0);
        chk("bp_head", out_data, 16'h3210);
        out_ready = 1'b1;
        for (int i = 11; i < 16; i++) send(4'(i), 1'b0);
        wait_drain();

        // Partial flush, then a normal word.
        expect_word(16'h00BA, 1'b1); expect_word(16'h4321, 1'b0);
        send(4'hA, 1'b0); send(4'hB, 1'b0);
        flush_pulse();
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        wait_drain();

        // Flush with a concurrent nibble, then an empty flush.
        expect_word(16'h0765, 1'b1);
        send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b1);
        wait_drain();
        flush_pulse();
        repeat (2) @(posedge clk);
        #1;
        chk("empty_flush_no_push", 16'(out_valid), 16'h0);

        // Flush while full.
        out_ready = 1'b0;
        expect_word(16'h4321, 1'b0); expect_word(16'h8765, 1'b0); expect_word(16'h0009, 1'b1);
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
        send(4'h9, 1'b0);
        flush_pulse();
        chk("full_flush_in_ready", 16'(in_ready), 16'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("full_flush_still_pending", 16'(in_ready), 16'h0);
        @(posedge clk); #1;
        chk("full_flush_back_to_fill", 16'(in_ready), 16'h1);
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-word.
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_out_valid", 16'(out_valid), 16'h0);
        chk("midreset_in_ready", 16'(in_ready), 16'h1);
        expect_word(16'h8765, 1'b0);
        send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
        wait_drain();
        chk("final_idle", 16'(out_valid), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
